fifo_stream_reader: RTL and testbench

Read-side consumer for the asynchronous FIFO. It drains the FIFO's read port (`empty`, `read_en`, combinational `read_data`) and presents the words as a registered valid/ready stream. A two-entry skid buffer sustains one word per cycle while keeping `m_ready` out of the `fifo_read_en` path. It lives entirely in the read clock domain and also provides a flush control and a running transferred-word count.

---
 rtl/fifo_stream_reader.sv | 109 ++++++++++
 tb/tb_fifo_stream_reader.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// Read-side drain for the async FIFO: pops words into a two-entry skid
// buffer and presents them as a registered valid/ready stream.
module fifo_stream_reader #(
    parameter int WIDTH       = 32,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   fifo_empty,
    input  logic [WIDTH-1:0]       fifo_read_data,
    output logic                   fifo_read_en,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [WIDTH-1:0]       m_data,
    input  logic                   flush,
    output logic [COUNT_WIDTH-1:0] word_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] skid;
    logic             active;
    logic             pop;
    logic             drain;
    logic             load_head_fifo;
    logic             load_head_skid;
    logic             load_skid;

    // Pop never looks at m_ready, so the FIFO read path stays short.
    assign pop          = active && !fifo_empty && !flush && (state != TWO);
    assign fifo_read_en = pop;
    assign m_valid      = (state != EMPTY);
    assign drain        = m_valid && m_ready;
    assign m_data       = head;

    always_comb begin
        state_next     = state;
        load_head_fifo = 1'b0;
        load_head_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_next = EMPTY;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (pop) begin
                        state_next     = ONE;
                        load_head_fifo = 1'b1;
                    end
                end
                ONE: begin
                    if (pop && !drain) begin
                        state_next = TWO;
                        load_skid  = 1'b1;
                    end else if (pop && drain) begin
                        load_head_fifo = 1'b1;
                    end else if (drain) begin
                        state_next = EMPTY;
                    end
                end
                TWO: begin
                    if (drain) begin
                        state_next     = ONE;
                        load_head_skid = 1'b1;
                    end
                end
                default: state_next = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= EMPTY;
            active     <= 1'b0;
            word_count <= '0;
        end else begin
            state  <= state_next;
            active <= 1'b1;
            if (drain) begin
                word_count <= word_count + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head <= '0;
            skid <= '0;
        end else begin
            if (load_head_fifo) begin
                head <= fifo_read_data;
            end else if (load_head_skid) begin
                head <= skid;
            end
            if (load_skid) begin
                skid <= fifo_read_data;
            end
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader: a queue models the FIFO read
// port, drained words are logged per cycle and checked against constants.
module tb_fifo_stream_reader;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        fifo_empty;
    logic [31:0] fifo_read_data;
    logic        m_ready;
    logic        flush;
    logic        fifo_read_en;
    logic        m_valid;
    logic [31:0] m_data;
    logic [15:0] word_count;
    logic        fifo_read_en4;
    logic        m_valid4;
    logic [31:0] m_data4;
    logic [3:0]  word_count4;

    logic [31:0] q[$];
    int          pop_log[$];
    int          drn_cyc[$];
    logic [31:0] drn_dat[$];
    int          cyc;
    int          bad_pop;
    int          checks;
    int          errors;

    always #5 clk = ~clk;

    fifo_stream_reader #(.WIDTH(32), .COUNT_WIDTH(16)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .fifo_empty     (fifo_empty),
        .fifo_read_data (fifo_read_data),
        .fifo_read_en   (fifo_read_en),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_data         (m_data),
        .flush          (flush),
        .word_count     (word_count)
    );

    fifo_stream_reader #(.WIDTH(32), .COUNT_WIDTH(4)) dut4 (
        .clk            (clk),
        .reset_n        (reset_n),
        .fifo_empty     (fifo_empty),
        .fifo_read_data (fifo_read_data),
        .fifo_read_en   (fifo_read_en4),
        .m_valid        (m_valid4),
        .m_ready        (m_ready),
        .m_data         (m_data4),
        .flush          (flush),
        .word_count     (word_count4)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic refresh();
        fifo_empty     = (q.size() == 0);
        fifo_read_data = fifo_empty ? 32'hDEAD_BEEF : q[0];
    endtask

    task automatic clear_logs();
        pop_log.delete();
        drn_cyc.delete();
        drn_dat.delete();
        cyc = 0;
    endtask

    // One clock: sample pop/drain before the edge, apply the pop after it.
    task automatic step();
        logic        p;
        logic        d;
        logic        hold;
        logic [31:0] hd;
        refresh();
        #1;
        p    = fifo_read_en;
        d    = m_valid && m_ready;
        hold = m_valid && !m_ready && !flush;
        hd   = m_data;
        if ((fifo_read_en || fifo_read_en4) && fifo_empty) bad_pop++;
        if (p) pop_log.push_back(cyc);
        if (d) begin
            drn_cyc.push_back(cyc);
            drn_dat.push_back(m_data);
        end
        @(posedge clk);
        @(negedge clk);
        if (p) void'(q.pop_front());
        refresh();
        if (hold) begin
            check("hold_valid", m_valid, 1);
            check("hold_data", m_data, hd);
        end
        cyc++;
    endtask

    task automatic run_until(input string tag, input int n, input int budget);
        int b;
        b = budget;
        while (drn_dat.size() < n && b > 0) begin
            step();
            b--;
        end
        check(tag, drn_dat.size(), n);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        checks  = 0;
        errors  = 0;
        bad_pop = 0;
        reset_n = 1'b0;
        flush   = 1'b0;
        m_ready = 1'b1;
        clear_logs();

        // reset, then three words streamed with m_ready high
        q = '{32'hA5A5_0001, 32'hA5A5_0002, 32'hA5A5_0003};
        refresh();
        repeat (2) @(negedge clk);
        #1;
        check("rst_valid", m_valid, 0);
        check("rst_data", m_data, 0);
        check("rst_count", word_count, 0);
        check("rst_count4", word_count4, 0);
        check("rst_ren", fifo_read_en, 0);
        reset_n = 1'b1;
        clear_logs();
        run_until("s1_done", 3, 20);
        check("s1_first_pop", pop_log[0], 1);
        check("s1_latency", drn_cyc[0] - pop_log[0], 1);
        check("s1_back2back", drn_cyc[2] - drn_cyc[0], 2);
        check("s1_w0", drn_dat[0], 32'hA5A5_0001);
        check("s1_w1", drn_dat[1], 32'hA5A5_0002);
        check("s1_w2", drn_dat[2], 32'hA5A5_0003);
        check("s1_count", word_count, 3);

        // backpressure: m_ready low for five cycles with four words queued
        clear_logs();
        q = '{32'd1, 32'd2, 32'd3, 32'd4};
        m_ready = 1'b0;
        repeat (5) step();
        check("bp_pops", pop_log.size(), 2);
        check("bp_valid", m_valid, 1);
        check("bp_data", m_data, 1);
        #1;
        check("bp_ren", fifo_read_en, 0);
        m_ready = 1'b1;
        run_until("bp_done", 4, 20);
        for (int i = 0; i < 4; i++) check("bp_word", drn_dat[i], i + 1);
        check("bp_back2back", drn_cyc[3] - drn_cyc[0], 3);
        check("bp_resume", pop_log[2] - drn_cyc[0], 1);
        check("bp_count", word_count, 7);

        // random m_ready over 1000 incrementing words
        clear_logs();
        for (int i = 0; i < 1000; i++) q.push_back(i);
        for (int b = 0; b < 10000 && drn_dat.size() < 1000; b++) begin
            m_ready = 1'($urandom_range(0, 1));
            step();
        end
        check("rnd_done", drn_dat.size(), 1000);
        for (int i = 0; i < 1000; i++) check("rnd_word", drn_dat[i], i);
        check("rnd_count", word_count, 1007);
        check("rnd_count4", word_count4, 15);

        // flush while holding 7 and 8 in TWO
        clear_logs();
        m_ready = 1'b0;
        q = '{32'd7, 32'd8};
        step();
        step();
        check("fl_pre_valid", m_valid, 1);
        check("fl_pre_data", m_data, 7);
        q.push_back(32'd9);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("fl_valid", m_valid, 0);
        check("fl_pops", pop_log.size(), 2);
        step();
        check("fl_w9_latency", cyc - 1 - pop_log[2], 0);
        check("fl_w9_valid", m_valid, 1);
        check("fl_w9_data", m_data, 9);
        check("fl_count_held", word_count, 1007);
        m_ready = 1'b1;
        step();
        check("fl_count9", word_count, 1008);

        // flush in ONE with a handshake on the same edge
        m_ready = 1'b0;
        q = '{32'd10};
        step();
        q.push_back(32'd11);
        m_ready = 1'b1;
        flush = 1'b1;
        refresh();
        #1;
        check("fl_ren", fifo_read_en, 0);
        step();
        flush = 1'b0;
        check("fl1_valid", m_valid, 0);
        check("fl1_count", word_count, 1009);
        run_until("fl_done", 3, 10);
        check("fl_out0", drn_dat[0], 9);
        check("fl_out1", drn_dat[1], 10);
        check("fl_out2", drn_dat[2], 11);
        check("fl_count", word_count, 1010);

        // asynchronous reset while in ONE
        clear_logs();
        m_ready = 1'b0;
        q = '{32'd20, 32'd21, 32'd22};
        step();
        check("mr_pre_valid", m_valid, 1);
        reset_n = 1'b0;
        #1;
        check("mr_valid", m_valid, 0);
        check("mr_data", m_data, 0);
        check("mr_count", word_count, 0);
        check("mr_ren", fifo_read_en, 0);
        reset_n = 1'b1;
        clear_logs();
        m_ready = 1'b1;
        run_until("mr_done", 2, 20);
        check("mr_first_pop", pop_log[0], 1);
        check("mr_w0", drn_dat[0], 21);
        check("mr_w1", drn_dat[1], 22);
        check("mr_count", word_count, 2);

        // 17 words through the 4-bit counter instance
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
        clear_logs();
        for (int i = 0; i < 17; i++) q.push_back(100 + i);
        step();
        step();
        check("w4_valid", m_valid4, 1);
        check("w4_data", m_data4, 100);
        run_until("w4_done", 17, 40);
        check("w4_count4", word_count4, 1);
        check("w4_count", word_count, 17);
        check("no_bad_pop", bad_pop, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
